// File: rtl/register_file_mp.sv
// Multi-port register file with x0 hardwired to zero and a per-register busy scoreboard.
// Define RF_BYPASS_EN to forward same-cycle write data (and busy clear) to the read ports.
module register_file_mp #(
   parameter int unsigned XLEN   = 64,
   parameter int unsigned NREGS  = 32,
   parameter int unsigned ADDR_W = 5,
   parameter int unsigned NREAD  = 2,
   parameter int unsigned NWRITE = 2
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NREAD*ADDR_W-1:0]  rs_addr,
   output logic [NREAD*XLEN-1:0]    rd_data,
   output logic [NREAD-1:0]         rs_busy,
   input  logic [NWRITE-1:0]        wr_en,
   input  logic [NWRITE*ADDR_W-1:0] wr_addr,
   input  logic [NWRITE*XLEN-1:0]   wr_data,
   input  logic                     alloc_en,
   input  logic [ADDR_W-1:0]        alloc_rd,
   output logic [ADDR_W:0]          busy_count
);

   localparam int unsigned CntW = ADDR_W + 1;

   logic [XLEN-1:0]  regs_q [NREGS];
   logic [XLEN-1:0]  regs_d [NREGS];
   logic [NREGS-1:0] busy_q;
   logic [NREGS-1:0] busy_d;
   logic [CntW-1:0]  count_q;
   logic [CntW-1:0]  count_d;

   // Ascending port order lets the highest-index write win; allocation is applied last so it
   // dominates a same-cycle writeback to the same register.
   always_comb begin
      regs_d = regs_q;
      busy_d = busy_q;
      for (int j = 0; j < NWRITE; j++) begin
         if (wr_en[j] && (wr_addr[j*ADDR_W +: ADDR_W] != '0)) begin
            regs_d[wr_addr[j*ADDR_W +: ADDR_W]] = wr_data[j*XLEN +: XLEN];
            busy_d[wr_addr[j*ADDR_W +: ADDR_W]] = 1'b0;
         end
      end
      if (alloc_en && (alloc_rd != '0)) begin
         busy_d[alloc_rd] = 1'b1;
      end
      count_d = '0;
      for (int i = 0; i < NREGS; i++) begin
         count_d = count_d + CntW'(busy_d[i]);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NREGS; i++) begin
            regs_q[i] <= '0;
         end
         busy_q  <= '0;
         count_q <= '0;
      end else begin
         regs_q  <= regs_d;
         busy_q  <= busy_d;
         count_q <= count_d;
      end
   end

   always_comb begin : read_ports
      logic [ADDR_W-1:0] ra;
      rd_data = '0;
      rs_busy = '0;
      for (int i = 0; i < NREAD; i++) begin
         ra = rs_addr[i*ADDR_W +: ADDR_W];
         if (ra != '0) begin
            rd_data[i*XLEN +: XLEN] = regs_q[ra];
            rs_busy[i]              = busy_q[ra];
`ifdef RF_BYPASS_EN
            for (int j = 0; j < NWRITE; j++) begin
               if (wr_en[j] && (wr_addr[j*ADDR_W +: ADDR_W] == ra)) begin
                  rd_data[i*XLEN +: XLEN] = wr_data[j*XLEN +: XLEN];
                  rs_busy[i]              = alloc_en && (alloc_rd == ra);
               end
            end
`endif
         end
      end
   end

   assign busy_count = count_q;

endmodule

// File: tb/tb_register_file_mp.sv
// Self-checking bench for register_file_mp: directed scenarios plus randomized traffic
// checked against an array-based reference model. Honors RF_BYPASS_EN when defined.
module tb_register_file_mp;

   localparam int XLEN   = 64;
   localparam int NREGS  = 32;
   localparam int ADDR_W = 5;
   localparam int NREAD  = 2;
   localparam int NWRITE = 2;

   logic                     clk = 1'b0;
   logic                     reset;
   logic [NREAD*ADDR_W-1:0]  rs_addr;
   logic [NREAD*XLEN-1:0]    rd_data;
   logic [NREAD-1:0]         rs_busy;
   logic [NWRITE-1:0]        wr_en;
   logic [NWRITE*ADDR_W-1:0] wr_addr;
   logic [NWRITE*XLEN-1:0]   wr_data;
   logic                     alloc_en;
   logic [ADDR_W-1:0]        alloc_rd;
   logic [ADDR_W:0]          busy_count;

   int checks = 0;
   int errors = 0;

`ifdef RF_BYPASS_EN
   localparam bit Bypass = 1'b1;
`else
   localparam bit Bypass = 1'b0;
`endif

   // Reference model state
   logic [XLEN-1:0] m_regs [NREGS];
   bit              m_busy [NREGS];

   register_file_mp dut (
      .clk        (clk),
      .reset      (reset),
      .rs_addr    (rs_addr),
      .rd_data    (rd_data),
      .rs_busy    (rs_busy),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .alloc_en   (alloc_en),
      .alloc_rd   (alloc_rd),
      .busy_count (busy_count)
   );

   always #5 clk = ~clk;

   function automatic int model_count();
      int n = 0;
      for (int i = 0; i < NREGS; i++) n += int'(m_busy[i]);
      return n;
   endfunction

   function automatic logic [XLEN-1:0] model_data(input int a);
      logic [XLEN-1:0] v;
      if (a == 0) return '0;
      v = m_regs[a];
      if (Bypass) begin
         for (int j = 0; j < NWRITE; j++)
            if (wr_en[j] && int'(wr_addr[j*ADDR_W +: ADDR_W]) == a) v = wr_data[j*XLEN +: XLEN];
      end
      return v;
   endfunction

   function automatic bit model_busy(input int a);
      bit b;
      if (a == 0) return 1'b0;
      b = m_busy[a];
      if (Bypass) begin
         for (int j = 0; j < NWRITE; j++)
            if (wr_en[j] && int'(wr_addr[j*ADDR_W +: ADDR_W]) == a)
               b = alloc_en && (int'(alloc_rd) == a);
      end
      return b;
   endfunction

   // Advance one clock edge and apply the same edge to the model.
   task automatic tick();
      @(posedge clk);
      if (reset) begin
         for (int i = 0; i < NREGS; i++) begin
            m_regs[i] = '0;
            m_busy[i] = 1'b0;
         end
      end else begin
         for (int j = 0; j < NWRITE; j++) begin
            int a = int'(wr_addr[j*ADDR_W +: ADDR_W]);
            if (wr_en[j] && a != 0) begin
               m_regs[a] = wr_data[j*XLEN +: XLEN];
               m_busy[a] = 1'b0;
            end
         end
         if (alloc_en && alloc_rd != 0) m_busy[int'(alloc_rd)] = 1'b1;
      end
      #1;
   endtask

   task automatic idle_inputs();
      reset    = 1'b0;
      wr_en    = '0;
      wr_addr  = '0;
      wr_data  = '0;
      alloc_en = 1'b0;
      alloc_rd = '0;
   endtask

   task automatic set_write(input int p, input int a, input logic [XLEN-1:0] d);
      wr_en[p]                  = 1'b1;
      wr_addr[p*ADDR_W +: ADDR_W] = ADDR_W'(a);
      wr_data[p*XLEN +: XLEN]   = d;
   endtask

   task automatic read_both(input int a);
      rs_addr = {ADDR_W'(a), ADDR_W'(a)};
      #1;
   endtask

   task automatic test_reset();
      idle_inputs();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      for (int a = 0; a < NREGS; a++) begin
         read_both(a);
         for (int p = 0; p < NREAD; p++) begin
            checks++;
            if (rd_data[p*XLEN +: XLEN] !== '0 || rs_busy[p] !== 1'b0) begin
               errors++;
               $display("FAIL reset_read a=%0d p=%0d: got data=%h busy=%b, expected 0/0",
                        a, p, rd_data[p*XLEN +: XLEN], rs_busy[p]);
            end
         end
      end
      checks++;
      if (busy_count !== '0) begin
         errors++;
         $display("FAIL reset_count: got %0d expected 0", busy_count);
      end
   endtask

   task automatic test_write_read();
      logic [XLEN-1:0] same_exp;
      idle_inputs();
      set_write(0, 5, 64'h1234);
      read_both(5);
      same_exp = Bypass ? 64'h1234 : 64'h0;
      checks++;
      if (rd_data[XLEN-1:0] !== same_exp) begin
         errors++;
         $display("FAIL x5_same_cycle: got %h expected %h", rd_data[XLEN-1:0], same_exp);
      end
      tick();
      idle_inputs();
      read_both(5);
      for (int p = 0; p < NREAD; p++) begin
         checks++;
         if (rd_data[p*XLEN +: XLEN] !== 64'h1234) begin
            errors++;
            $display("FAIL x5_read p=%0d: got %h expected 1234", p, rd_data[p*XLEN +: XLEN]);
         end
      end
      set_write(0, 0, 64'hFFFF);
      read_both(0);
      checks++;
      if (rd_data !== '0) begin
         errors++;
         $display("FAIL x0_same_cycle: got %h expected 0", rd_data);
      end
      tick();
      idle_inputs();
      read_both(0);
      checks++;
      if (rd_data !== '0 || rs_busy !== '0) begin
         errors++;
         $display("FAIL x0_read: got %h/%b expected 0/0", rd_data, rs_busy);
      end
   endtask

   task automatic test_same_addr();
      idle_inputs();
      set_write(0, 7, 64'hAA);
      set_write(1, 7, 64'hBB);
      tick();
      idle_inputs();
      read_both(7);
      checks++;
      if (rd_data[XLEN +: XLEN] !== 64'hBB || rd_data[XLEN-1:0] !== 64'hBB) begin
         errors++;
         $display("FAIL same_addr_priority: got %h expected BB on both", rd_data);
      end
   endtask

   task automatic test_scoreboard();
      int exp_cnt [3] = '{1, 2, 2};
      int seq [3] = '{3, 9, 3};
      for (int k = 0; k < 3; k++) begin
         idle_inputs();
         alloc_en = 1'b1;
         alloc_rd = ADDR_W'(seq[k]);
         tick();
         idle_inputs();
         #1;
         checks++;
         if (int'(busy_count) != exp_cnt[k]) begin
            errors++;
            $display("FAIL alloc_count step=%0d: got %0d expected %0d", k, busy_count, exp_cnt[k]);
         end
      end
      set_write(1, 9, 64'h9);
      tick();
      idle_inputs();
      read_both(9);
      checks++;
      if (rs_busy !== 2'b00 || busy_count !== 6'd1) begin
         errors++;
         $display("FAIL writeback_clear: got busy=%b count=%0d expected 00/1", rs_busy, busy_count);
      end
      alloc_en = 1'b1;
      alloc_rd = 5'd3;
      set_write(0, 3, 64'h33);
      tick();
      idle_inputs();
      read_both(3);
      checks++;
      if (rs_busy !== 2'b11 || busy_count !== 6'd1 || rd_data[XLEN-1:0] !== 64'h33) begin
         errors++;
         $display("FAIL alloc_dominates: got busy=%b count=%0d data=%h expected 11/1/33",
                  rs_busy, busy_count, rd_data[XLEN-1:0]);
      end
   endtask

   task automatic test_reset_mid();
      idle_inputs();
      alloc_en = 1'b1;
      alloc_rd = 5'd4;
      set_write(0, 4, 64'h55);
      tick();
      idle_inputs();
      reset = 1'b1;
      set_write(1, 4, 64'h77);
      alloc_en = 1'b1;
      alloc_rd = 5'd4;
      tick();
      idle_inputs();
      read_both(4);
      checks++;
      if (rd_data !== '0 || rs_busy !== '0 || busy_count !== '0) begin
         errors++;
         $display("FAIL reset_mid: got data=%h busy=%b count=%0d expected 0/0/0",
                  rd_data, rs_busy, busy_count);
      end
   endtask

   task automatic test_bypass();
      logic [XLEN-1:0] exp_d;
      logic            exp_b;
      idle_inputs();
      alloc_en = 1'b1;
      alloc_rd = 5'd10;
      tick();
      idle_inputs();
      set_write(0, 10, 64'h99);
      read_both(10);
      exp_d = Bypass ? 64'h99 : 64'h0;
      exp_b = Bypass ? 1'b0 : 1'b1;
      checks++;
      if (rd_data[XLEN-1:0] !== exp_d || rs_busy[0] !== exp_b) begin
         errors++;
         $display("FAIL bypass_same_cycle: got %h/%b expected %h/%b",
                  rd_data[XLEN-1:0], rs_busy[0], exp_d, exp_b);
      end
      tick();
      idle_inputs();
      read_both(10);
      checks++;
      if (rd_data[XLEN-1:0] !== 64'h99 || rs_busy[0] !== 1'b0) begin
         errors++;
         $display("FAIL bypass_next_cycle: got %h/%b expected 99/0", rd_data[XLEN-1:0], rs_busy[0]);
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         int hi = ($urandom_range(0, 3) == 0) ? NREGS - 1 : 7;
         reset    = ($urandom_range(0, 59) == 0);
         wr_en    = NWRITE'($urandom);
         alloc_en = $urandom_range(0, 1) == 1;
         alloc_rd = ADDR_W'($urandom_range(0, hi));
         for (int j = 0; j < NWRITE; j++) begin
            wr_addr[j*ADDR_W +: ADDR_W] = ADDR_W'($urandom_range(0, hi));
            wr_data[j*XLEN +: XLEN]     = {$urandom, $urandom};
         end
         for (int p = 0; p < NREAD; p++) rs_addr[p*ADDR_W +: ADDR_W] = ADDR_W'($urandom_range(0, hi));
         #1;
         for (int p = 0; p < NREAD; p++) begin
            int a = int'(rs_addr[p*ADDR_W +: ADDR_W]);
            logic [XLEN-1:0] ed = model_data(a);
            bit eb = model_busy(a);
            checks++;
            if (rd_data[p*XLEN +: XLEN] !== ed || rs_busy[p] !== eb) begin
               errors++;
               $display("FAIL rand_read c=%0d p=%0d a=%0d: got %h/%b expected %h/%b",
                        c, p, a, rd_data[p*XLEN +: XLEN], rs_busy[p], ed, eb);
            end
         end
         checks++;
         if (int'(busy_count) != model_count()) begin
            errors++;
            $display("FAIL rand_count c=%0d: got %0d expected %0d", c, busy_count, model_count());
         end
         tick();
      end
   endtask

   initial begin
      rs_addr = '0;
      idle_inputs();
      reset = 1'b1;
      for (int i = 0; i < NREGS; i++) begin
         m_regs[i] = '0;
         m_busy[i] = 1'b0;
      end
      #1;
      test_reset();
      test_write_read();
      test_same_addr();
      test_scoreboard();
      test_reset_mid();
      test_bypass();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
